mult_datapath: RTL and testbench

- Shift-add datapath for the sequential multiplier, directly downstream of the multiplier control FSM.
- Consumes the ADD, SHIFT, RESET, DECREMENT and READY strobes.
- Returns the working register and iteration count that the FSM decides on.
- Captures the final product for the consumer.

---
 rtl/mult_pkg.sv | 19 +
 rtl/mult_counter.sv | 23 ++
 rtl/mult_datapath.sv | 78 +++++++
 tb/tb_mult_datapath.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier (datapath and control FSM).
// Operand width and derived register/counter widths live here.
package mult_pkg;

  localparam int WIDTH = 8;
  localparam int REG_W = 2*WIDTH + 1;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef logic [REG_W-1:0] mult_reg_t;
  typedef logic [CNT_W-1:0] mult_cnt_t;

  // Counter preload: WIDTH-1 plus the final pass at zero gives WIDTH iterations.
  localparam mult_cnt_t CNT_INIT = mult_cnt_t'(WIDTH - 1);

  function automatic mult_cnt_t sat_dec(input mult_cnt_t c);
    return (c == '0) ? '0 : c - 1'b1;
  endfunction

endpackage

// File: rtl/mult_counter.sv
// Loadable down counter that saturates at zero; tracks remaining multiply iterations.
module mult_counter
  import mult_pkg::*;
(
  input  logic      clk,
  input  logic      n_reset,
  input  logic      load,
  input  mult_cnt_t load_val,
  input  logic      dec,
  output mult_cnt_t count
);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= sat_dec(count);
    end
  end

endmodule

// File: rtl/mult_datapath.sv
// Shift-add datapath for the sequential multiplier, driven by the control FSM strobes.
// Optional macro MULT_DP_PRODUCT_REG_EN registers P and shapes DONE into a one-cycle pulse.
module mult_datapath
  import mult_pkg::*;
(
  input  logic               clk,
  input  logic               n_reset,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               RESET,
  input  logic               ADD,
  input  logic               SHIFT,
  input  logic               DECREMENT,
  input  logic               READY,
  output mult_reg_t          register,
  output mult_cnt_t          count,
  output logic [2*WIDTH-1:0] P,
  output logic               DONE
);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH:0]   sum;

  assign sum = {1'b0, register[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};

  // RESET wins over every other strobe; ADD+SHIFT folds the add into the shift.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      register <= '0;
      mcand_q  <= '0;
    end else if (RESET) begin
      register <= {1'b0, {WIDTH{1'b0}}, B};
      mcand_q  <= A;
    end else begin
      unique case ({ADD, SHIFT})
        2'b11:   register <= {1'b0, sum, register[WIDTH-1:1]};
        2'b01:   register <= register >> 1;
        2'b10:   register <= {sum, register[WIDTH-1:0]};
        default: register <= register;
      endcase
    end
  end

  mult_counter u_counter (
    .clk      (clk),
    .n_reset  (n_reset),
    .load     (RESET),
    .load_val (CNT_INIT),
    .dec      (DECREMENT),
    .count    (count)
  );

`ifdef MULT_DP_PRODUCT_REG_EN
  logic ready_q;
  logic ready_rise;

  assign ready_rise = READY & ~ready_q;

  // P is captured on the READY edge; RESET only kills a pending DONE, never P.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ready_q <= 1'b0;
      P       <= '0;
      DONE    <= 1'b0;
    end else begin
      ready_q <= READY;
      DONE    <= ready_rise & ~RESET;
      if (ready_rise) begin
        P <= register[2*WIDTH-1:0];
      end
    end
  end
`else
  assign P    = register[2*WIDTH-1:0];
  assign DONE = READY;
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// Scoreboard bench for mult_datapath: products are queued at RESET and checked on DONE.
// Works with or without MULT_DP_PRODUCT_REG_EN.
module tb_mult_datapath;
  import mult_pkg::*;

  logic               clk;
  logic               n_reset;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               RESET;
  logic               ADD;
  logic               SHIFT;
  logic               DECREMENT;
  logic               READY;
  mult_reg_t          register;
  mult_cnt_t          count;
  logic [2*WIDTH-1:0] P;
  logic               DONE;

  int checksDone   = 0;
  int checksPassed = 0;
  logic [2*WIDTH-1:0] sb[$];
  logic [2*WIDTH-1:0] lastProduct = '0;

  mult_datapath dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .A         (A),
    .B         (B),
    .RESET     (RESET),
    .ADD       (ADD),
    .SHIFT     (SHIFT),
    .DECREMENT (DECREMENT),
    .READY     (READY),
    .register  (register),
    .count     (count),
    .P         (P),
    .DONE      (DONE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checksDone++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
  endtask

  // Drives one cycle of strobes at the falling edge; optionally ADD follows register[0].
  task automatic applyStimulus(input logic rstS, input logic addS, input logic shiftS,
                               input logic decS, input logic readyS, input bit addFromLsb);
    @(negedge clk);
    RESET     = rstS;
    ADD       = addFromLsb ? register[0] : addS;
    SHIFT     = shiftS;
    DECREMENT = decS;
    READY     = readyS;
  endtask

  task automatic startRun(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] expProd;
    A = a;
    B = b;
    applyStimulus(1, 0, 0, 0, 0, 0);
    expProd = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    sb.push_back(expProd);
  endtask

  task automatic iterate(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 1, 1, 0, 1);
  endtask

  task automatic finishRun(input string tag);
    bit found = 0;
    logic [2*WIDTH-1:0] expProd;
    applyStimulus(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      if (DONE) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    expProd = sb.pop_front();
    if (!found) begin
      checkOutput({tag, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      checkOutput({tag, "_P"}, P, expProd);
      checkOutput({tag, "_count"}, count, 0);
      checkOutput({tag, "_carry"}, register[2*WIDTH], 0);
      lastProduct = expProd;
`ifdef MULT_DP_PRODUCT_REG_EN
      applyStimulus(0, 0, 0, 0, 1, 0);
      #1;
      checkOutput({tag, "_done_pulse"}, DONE, 0);
`endif
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic fullRun(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
    startRun(a, b);
    iterate(WIDTH);
    finishRun(tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    n_reset = 1'b0;
    {A, B} = '0;
    {RESET, ADD, SHIFT, DECREMENT, READY} = '0;
    #12;
    checkOutput("rst_register", register, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_P", P, 0);
    checkOutput("rst_DONE", DONE, 0);
    #10 n_reset = 1'b1;

    fullRun("basic_13x11", 8'd13, 8'd11);
    fullRun("max_255x255", 8'd255, 8'd255);
    fullRun("zero_a", 8'd0, 8'd200);
    fullRun("zero_b", 8'd200, 8'd0);
    for (int r = 0; r < 4; r++) begin
      fullRun("random", WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)));
    end

    // Counter already at zero after the last run; extra decrements must not wrap.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1 checkOutput("sat_count", count, 0);

    A = 8'd3;
    B = 8'd5;
    applyStimulus(1, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1 checkOutput("reset_dec_count", count, 7);

    A = 8'h33;
    B = 8'h5A;
    applyStimulus(1, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1 checkOutput("reset_prio_reg", register, 17'h0005A);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1 checkOutput("add_only_reg", register, 17'h0335A);

    // Two ADD-only cycles of 255 push a carry into register[16].
    A = 8'hFF;
    B = 8'hFF;
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1 checkOutput("carry_reg", register, 17'h1FEFF);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1 checkOutput("shift_only_reg", register, 17'h0FF7F);
`ifdef MULT_DP_PRODUCT_REG_EN
    checkOutput("P_hold", P, lastProduct);
`endif

    startRun(8'd100, 8'd77);
    iterate(4);
    #2 n_reset = 1'b0;
    #1;
    checkOutput("abort_register", register, 0);
    checkOutput("abort_count", count, 0);
    checkOutput("abort_P", P, 0);
    checkOutput("abort_DONE", DONE, 0);
    sb.delete();
    {RESET, ADD, SHIFT, DECREMENT, READY} = '0;
    #1 n_reset = 1'b1;
    fullRun("after_abort_6x7", 8'd6, 8'd7);

    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end

endmodule
